i2c_slave_ctrl: RTL and testbench

- Downstream consumer of the I2C decode stage.
- Takes start/stop/address-match/rw indications plus raw SCL/SDA.
- Tracks SCL edges and bit position, and sequences the whole slave transaction: address phase, ACK/NACK, receive bytes and transmit bytes.
- Drives the rx/tx shift-register strobes, TX-FIFO pop and the SDA output mux select for the slave front end.

---
 rtl/i2c_slave_ctrl.sv | 213 +++++++++++++++++++++
 tb/tb_i2c_slave_ctrl.sv | 338 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/i2c_slave_ctrl.sv
// -----------------------------------------------------------------------------
// i2c_slave_ctrl
//
// Transaction sequencer for the I2C slave front end. Sits behind the start/stop
// and address decode stage, watches the raw bus lines through local
// synchronizers, and walks each slave transaction through its phases:
// address, address ACK, received data bytes with ACKs, and transmitted data
// bytes with master ACK/NACK checks.
//
// Ports:
//   clk            system clock
//   n_rst          asynchronous active-low reset
//   scl            raw bus SCL (synchronized here, 3 flops for edge detect)
//   sda_in         raw bus SDA (synchronized here, 2 flops; master ACK sampling)
//   start_found    one-cycle start / repeated-start pulse from decode
//   stop_found     one-cycle stop pulse from decode
//   address_match  first byte matched the slave address
//   rw_mode        R/W bit of the first byte (1 = master read)
//   rx_enable      strobe: rx shift register samples SDA
//   tx_enable      strobe: tx shift register advances to its next bit
//   load_data      strobe: tx shift register loads from the FIFO
//   read_fifo      strobe: TX-FIFO pop, always coincident with load_data
//   byte_received  registered pulse: a full write-data byte is in the rx register
//   sda_mode       registered SDA mux select:
//                    00 release, 01 drive 0 (ACK), 10 drive 1, 11 drive tx bit
//   busy           high whenever the sequencer is not idle
// -----------------------------------------------------------------------------
module i2c_slave_ctrl #(
  parameter int unsigned DATA_BITS = 8
) (
  input  logic       clk,
  input  logic       n_rst,
  input  logic       scl,
  input  logic       sda_in,
  input  logic       start_found,
  input  logic       stop_found,
  input  logic       address_match,
  input  logic       rw_mode,
  output logic       rx_enable,
  output logic       tx_enable,
  output logic       load_data,
  output logic       read_fifo,
  output logic       byte_received,
  output logic [1:0] sda_mode,
  output logic       busy
);

  localparam int unsigned CntW = $clog2(DATA_BITS + 1);

  localparam logic [CntW-1:0] CntZero    = '0;
  localparam logic [CntW-1:0] CntLast    = CntW'(DATA_BITS);
  localparam logic [CntW-1:0] CntPreLast = CntW'(DATA_BITS - 1);

  localparam logic [1:0] SdaRelease = 2'b00;
  localparam logic [1:0] SdaAck     = 2'b01;
  localparam logic [1:0] SdaTx      = 2'b11;

  typedef enum logic [3:0] {
    StIdle,
    StAddr,
    StAddrChk,
    StAckAddr,
    StRxByte,
    StAckRx,
    StTxByte,
    StChkAck,
    StSkip
  } state_e;

  state_e          state_q;
  logic [CntW-1:0] bit_cnt_q;
  logic            scl_q1, scl_q2, scl_q3;
  logic            sda_q1, sda_q2;

  logic scl_rise;
  logic scl_fall;
  logic bus_override;

  assign scl_rise     = scl_q2 & ~scl_q3;
  assign scl_fall     = ~scl_q2 & scl_q3;
  // Start/stop take priority over whatever the current state would do this cycle,
  // so no strobe may fire alongside them.
  assign bus_override = stop_found | start_found;

  assign busy = (state_q != StIdle);

  // Shift-register strobes are combinational so they line up with the edge pulse.
  always_comb begin
    rx_enable = 1'b0;
    tx_enable = 1'b0;
    load_data = 1'b0;
    if (!bus_override) begin
      rx_enable = scl_rise && ((state_q == StAddr) || (state_q == StRxByte));
      // Bit 1 is presented by the load; bits 2..DATA_BITS need an advance after
      // the falls that follow data rises 1..DATA_BITS-1.
      tx_enable = scl_fall && (state_q == StTxByte) &&
                  (bit_cnt_q != CntZero) && (bit_cnt_q < CntLast);
      // In the ACK states a zero count means the ACK rise has already passed,
      // so this fall closes the ACK slot.
      load_data = scl_fall && (bit_cnt_q == CntZero) &&
                  (((state_q == StAckAddr) && rw_mode) || (state_q == StChkAck));
    end
    read_fifo = load_data;
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state_q       <= StIdle;
      bit_cnt_q     <= '0;
      scl_q1        <= 1'b0;
      scl_q2        <= 1'b0;
      scl_q3        <= 1'b0;
      sda_q1        <= 1'b0;
      sda_q2        <= 1'b0;
      byte_received <= 1'b0;
      sda_mode      <= SdaRelease;
    end else begin
      scl_q1        <= scl;
      scl_q2        <= scl_q1;
      scl_q3        <= scl_q2;
      sda_q1        <= sda_in;
      sda_q2        <= sda_q1;
      byte_received <= 1'b0;

      if (stop_found) begin
        state_q   <= StIdle;
        bit_cnt_q <= '0;
        sda_mode  <= SdaRelease;
      end else if (start_found) begin
        state_q   <= StAddr;
        bit_cnt_q <= '0;
        sda_mode  <= SdaRelease;
      end else begin
        unique case (state_q)
          StIdle: begin
            sda_mode <= SdaRelease;
          end

          StAddr: begin
            if (scl_rise) begin
              bit_cnt_q <= bit_cnt_q + 1'b1;
              if (bit_cnt_q == CntPreLast) state_q <= StAddrChk;
            end
          end

          // Single settle cycle for the rx register and the address decode.
          StAddrChk: begin
            state_q <= address_match ? StAckAddr : StSkip;
          end

          // Count sits at DATA_BITS on entry: first fall drives the ACK, the ACK
          // rise wraps the count to zero, and the next fall ends the slot.
          StAckAddr, StAckRx: begin
            if (scl_fall && (bit_cnt_q == CntLast)) begin
              sda_mode <= SdaAck;
            end else if (scl_rise && (bit_cnt_q == CntLast)) begin
              bit_cnt_q <= '0;
            end else if (scl_fall && (bit_cnt_q == CntZero)) begin
              if ((state_q == StAckAddr) && rw_mode) begin
                sda_mode <= SdaTx;
                state_q  <= StTxByte;
              end else begin
                sda_mode <= SdaRelease;
                state_q  <= StRxByte;
              end
            end
          end

          StRxByte: begin
            if (scl_rise) begin
              bit_cnt_q <= bit_cnt_q + 1'b1;
              if (bit_cnt_q == CntPreLast) begin
                byte_received <= 1'b1;
                state_q       <= StAckRx;
              end
            end
          end

          StTxByte: begin
            if (scl_rise) begin
              bit_cnt_q <= bit_cnt_q + 1'b1;
            end else if (scl_fall && (bit_cnt_q == CntLast)) begin
              // Release the line so the master can drive its ACK bit.
              sda_mode <= SdaRelease;
              state_q  <= StChkAck;
            end
          end

          StChkAck: begin
            if (scl_rise && (bit_cnt_q == CntLast)) begin
              bit_cnt_q <= '0;
              if (sda_q2) state_q <= StSkip;
            end else if (scl_fall && (bit_cnt_q == CntZero)) begin
              sda_mode <= SdaTx;
              state_q  <= StTxByte;
            end
          end

          StSkip: begin
            sda_mode <= SdaRelease;
          end

          default: begin
            state_q   <= StIdle;
            bit_cnt_q <= '0;
            sda_mode  <= SdaRelease;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_i2c_slave_ctrl.sv
// -----------------------------------------------------------------------------
// tb_i2c_slave_ctrl
//
// Bus-level stimulus for i2c_slave_ctrl. Each transaction-level task pushes the
// output events the slave should produce (strobes, byte pulses, sda_mode
// changes) into a queue; an independent monitor turns observed DUT activity
// into the same event tokens and checks them in order.
// -----------------------------------------------------------------------------
module tb_i2c_slave_ctrl;

  localparam int H = 8;  // clk cycles per SCL half period

  localparam int EvRx   = 1;
  localparam int EvTx   = 2;
  localparam int EvLoad = 3;
  localparam int EvByte = 4;
  localparam int EvSda  = 16;  // EvSda + new sda_mode value

  logic       clk = 1'b0;
  logic       n_rst;
  logic       scl;
  logic       sda_in;
  logic       start_found;
  logic       stop_found;
  logic       address_match;
  logic       rw_mode;
  logic       rx_enable;
  logic       tx_enable;
  logic       load_data;
  logic       read_fifo;
  logic       byte_received;
  logic [1:0] sda_mode;
  logic       busy;

  int exp_q[$];
  int checks = 0;
  int errors = 0;
  logic [1:0] sda_prev = 2'b00;

  i2c_slave_ctrl #(.DATA_BITS(8)) dut (
    .clk          (clk),
    .n_rst        (n_rst),
    .scl          (scl),
    .sda_in       (sda_in),
    .start_found  (start_found),
    .stop_found   (stop_found),
    .address_match(address_match),
    .rw_mode      (rw_mode),
    .rx_enable    (rx_enable),
    .tx_enable    (tx_enable),
    .load_data    (load_data),
    .read_fifo    (read_fifo),
    .byte_received(byte_received),
    .sda_mode     (sda_mode),
    .busy         (busy)
  );

  always #5 clk = ~clk;

  function automatic string ev_name(input int e);
    case (e)
      EvRx:    return "rx_enable";
      EvTx:    return "tx_enable";
      EvLoad:  return "load_data+read_fifo";
      EvByte:  return "byte_received";
      default: return $sformatf("sda_mode=%0d", e - EvSda);
    endcase
  endfunction

  task automatic check_ev(input int got);
    int want;
    checks++;
    if (exp_q.size() == 0) begin
      errors++;
      $display("FAIL event_order: got %s, required no event (t=%0t)", ev_name(got), $time);
    end else begin
      want = exp_q.pop_front();
      if (want != got) begin
        errors++;
        $display("FAIL event_order: got %s, required %s (t=%0t)", ev_name(got), ev_name(want),
                 $time);
      end
    end
  endtask

  task automatic chk(input string name, input int got, input int want);
    checks++;
    if (got != want) begin
      errors++;
      $display("FAIL %s: got %0d, required %0d (t=%0t)", name, got, want, $time);
    end
  endtask

  // Monitor: sample away from the active edge and tokenise DUT activity.
  always @(negedge clk) begin
    if (rx_enable) check_ev(EvRx);
    if (tx_enable) check_ev(EvTx);
    if (load_data || read_fifo) begin
      check_ev(EvLoad);
      chk("pop_with_load", int'(read_fifo), int'(load_data));
    end
    if (byte_received) check_ev(EvByte);
    if (sda_mode !== sda_prev) begin
      check_ev(EvSda + int'(sda_mode));
      sda_prev <= sda_mode;
    end
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic push(input int e);
    exp_q.push_back(e);
  endtask

  task automatic drive_bit(input logic v);
    sda_in = v;
    tick(H);
    scl = 1'b1;
    tick(H);
    scl = 1'b0;
  endtask

  // Raise SCL and hold it high, as for the sampling half of a bit.
  task automatic high_half(input logic v);
    sda_in = v;
    tick(H);
    scl = 1'b1;
    tick(H);
  endtask

  task automatic start_cond();
    if (scl == 1'b0) high_half(1'b1);
    start_found = 1'b1;
    tick(1);
    start_found = 1'b0;
    tick(H);
    scl = 1'b0;
  endtask

  // rx_rise: the SCL rise ahead of the stop lands in a receiving phase.
  task automatic stop_cond(input logic rx_rise);
    if (scl == 1'b0) begin
      if (rx_rise) push(EvRx);
      high_half(1'b0);
    end
    stop_found = 1'b1;
    tick(1);
    stop_found = 1'b0;
    tick(H);
  endtask

  // Address phase: 8 sampled bits, then ACK for our address only. A write ACK
  // releases the line afterwards; a read ACK pops the FIFO and starts driving.
  task automatic xfer_addr(input logic [6:0] addr, input logic rw);
    logic [7:0] b;
    logic       match;
    b             = {addr, rw};
    match         = (addr == 7'h78);
    address_match = match;
    rw_mode       = rw;
    repeat (8) push(EvRx);
    if (match) begin
      push(EvSda + 1);
      if (rw) begin
        push(EvLoad);
        push(EvSda + 3);
      end else begin
        push(EvSda + 0);
      end
    end
    start_cond();
    for (int i = 7; i >= 0; i--) drive_bit(b[i]);
    drive_bit(1'b1);
  endtask

  task automatic write_byte(input logic [7:0] d);
    repeat (8) push(EvRx);
    push(EvByte);
    push(EvSda + 1);
    push(EvSda + 0);
    for (int i = 7; i >= 0; i--) drive_bit(d[i]);
    drive_bit(1'b1);
  endtask

  // ack=1: master pulls SDA low after the byte, asking for another one.
  task automatic read_byte(input logic ack);
    repeat (7) push(EvTx);
    push(EvSda + 0);
    if (ack) begin
      push(EvLoad);
      push(EvSda + 3);
    end
    repeat (8) drive_bit(1'b1);
    drive_bit(!ack);
  endtask

  task automatic skip_byte();
    repeat (9) drive_bit(1'($urandom_range(0, 1)));
  endtask

  task automatic partial_write(input int k);
    xfer_addr(7'h78, 1'b0);
    repeat (k) push(EvRx);
    repeat (k - 1) drive_bit(1'($urandom_range(0, 1)));
    high_half(1'($urandom_range(0, 1)));
    stop_cond(1'b0);
  endtask

  initial begin
    int         kind;
    int         n;
    logic [6:0] a;

    n_rst         = 1'b0;
    scl           = 1'b1;
    sda_in        = 1'b1;
    start_found   = 1'b0;
    stop_found    = 1'b0;
    address_match = 1'b0;
    rw_mode       = 1'b0;
    tick(4);
    chk("reset_rx_enable", int'(rx_enable), 0);
    chk("reset_tx_enable", int'(tx_enable), 0);
    chk("reset_load_data", int'(load_data), 0);
    chk("reset_read_fifo", int'(read_fifo), 0);
    chk("reset_byte_received", int'(byte_received), 0);
    chk("reset_sda_mode", int'(sda_mode), 0);
    chk("reset_busy", int'(busy), 0);
    n_rst = 1'b1;
    tick(4);
    chk("idle_busy", int'(busy), 0);

    // Matched write of 0xA5.
    xfer_addr(7'h78, 1'b0);
    chk("write_busy", int'(busy), 1);
    write_byte(8'hA5);
    stop_cond(1'b1);
    chk("write_stop_busy", int'(busy), 0);
    chk("write_stop_sda", int'(sda_mode), 0);

    // Read: master ACKs the first byte, NACKs the second.
    xfer_addr(7'h78, 1'b1);
    read_byte(1'b1);
    read_byte(1'b0);
    tick(4);
    chk("nack_skip_busy", int'(busy), 1);
    chk("nack_skip_sda", int'(sda_mode), 0);
    stop_cond(1'b0);
    chk("read_stop_busy", int'(busy), 0);

    // Address mismatch, followed by a byte the slave must ignore.
    xfer_addr(7'h52, 1'b0);
    skip_byte();
    stop_cond(1'b0);
    chk("mismatch_busy", int'(busy), 0);

    // Stop after 4 data bits of a write byte.
    partial_write(4);
    chk("partial_busy", int'(busy), 0);
    chk("partial_sda", int'(sda_mode), 0);

    // Repeated start while SCL is high in bit 3 of a transmitted byte.
    xfer_addr(7'h78, 1'b1);
    push(EvTx);
    push(EvTx);
    drive_bit(1'b1);
    drive_bit(1'b1);
    high_half(1'b1);
    push(EvSda + 0);
    xfer_addr(7'h78, 1'b0);
    write_byte(8'($urandom));
    stop_cond(1'b1);

    // Reset while the slave is driving the ACK of a received byte.
    xfer_addr(7'h78, 1'b0);
    repeat (8) push(EvRx);
    push(EvByte);
    push(EvSda + 1);
    repeat (8) drive_bit(1'($urandom_range(0, 1)));
    tick(4);
    chk("ack_rx_sda_before_reset", int'(sda_mode), 1);
    push(EvSda + 0);
    #3;
    n_rst = 1'b0;
    #1;
    chk("async_reset_sda", int'(sda_mode), 0);
    chk("async_reset_busy", int'(busy), 0);
    chk("async_reset_strobes", int'({rx_enable, tx_enable, load_data, read_fifo, byte_received}),
        0);
    tick(2);
    n_rst = 1'b1;
    repeat (10) drive_bit(1'($urandom_range(0, 1)));
    chk("post_reset_idle_busy", int'(busy), 0);
    xfer_addr(7'h78, 1'b0);
    write_byte(8'($urandom));
    stop_cond(1'b1);

    // Randomized mix of transaction shapes.
    for (int t = 0; t < 24; t++) begin
      kind = int'($urandom_range(0, 3));
      n    = int'($urandom_range(1, 3));
      case (kind)
        0: begin
          xfer_addr(7'h78, 1'b0);
          repeat (n) write_byte(8'($urandom));
          stop_cond(1'b1);
        end
        1: begin
          xfer_addr(7'h78, 1'b1);
          for (int i = 0; i < n; i++) read_byte(i < n - 1);
          stop_cond(1'b0);
        end
        2: begin
          a = 7'($urandom);
          while (a == 7'h78) a = 7'($urandom);
          xfer_addr(a, 1'($urandom_range(0, 1)));
          repeat (n) skip_byte();
          stop_cond(1'b0);
        end
        default: begin
          partial_write(int'($urandom_range(1, 7)));
        end
      endcase
      chk("random_end_busy", int'(busy), 0);
    end

    tick(20);
    chk("events_drained", exp_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
